multi_ctrl: RTL and testbench

//  Main controller FSM for the multicycle CPU core; replaces the single-cycle decoder.

---
 rtl/multi_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_multi_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_ctrl.sv
// Multicycle CPU main controller: sequences fetch/decode/execute/memory/writeback
// and counts retired instructions. Optional macro: MULTI_CTRL_ILLEGAL_TRAP_EN.
module multi_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       op,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_write,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_en,
  output logic [1:0]       pc_src,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic [CNT_W-1:0] retired,
  output logic [3:0]       state_dbg
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2,  MEMRD  = 4'd3,
    MEMWB  = 4'd4,  MEMWR  = 4'd5,  EXEC   = 4'd6,  ALUWB  = 4'd7,
    BRANCH = 4'd8,  ADDIEX = 4'd9,  ADDIWB = 4'd10, JUMP   = 4'd11,
    HALT   = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] retired_reg;
  logic             retire_inc;
  logic             pc_write, branch;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= FETCH;
      retired_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (retire_inc)
        retired_reg <= retired_reg + CNT_W'(1);
    end
  end

  always_comb begin
    state_next = state_reg;
    retire_inc = 1'b0;
    pc_write   = 1'b0;
    branch     = 1'b0;
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_src     = 2'b00;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;

    case (state_reg)
      FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = 2'b01;
        if (mem_ready) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          state_next = DECODE;
        end
      end
      DECODE: begin
        alu_src_b = 2'b11;
        case (op)
          OP_LW, OP_SW: state_next = MEMADR;
          OP_RTYPE:     state_next = EXEC;
          OP_BEQ:       state_next = BRANCH;
          OP_ADDI:      state_next = ADDIEX;
          OP_J:         state_next = JUMP;
`ifdef MULTI_CTRL_ILLEGAL_TRAP_EN
          default:      state_next = HALT;
`else
          default:      state_next = FETCH;
`endif
        endcase
      end
      MEMADR: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        state_next = (op == OP_SW) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (mem_ready) state_next = MEMWB;
      end
      MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire_inc = 1'b1;
        state_next = FETCH;
      end
      MEMWR: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        iord      = 1'b1;
        if (mem_ready) begin
          retire_inc = 1'b1;
          state_next = FETCH;
        end
      end
      EXEC: begin
        alu_src_a  = 1'b1;
        alu_op     = 2'b10;
        state_next = ALUWB;
      end
      ALUWB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        retire_inc = 1'b1;
        state_next = FETCH;
      end
      BRANCH: begin
        alu_src_a  = 1'b1;
        alu_op     = 2'b01;
        pc_src     = 2'b01;
        branch     = 1'b1;
        retire_inc = 1'b1;
        state_next = FETCH;
      end
      ADDIEX: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        state_next = ADDIWB;
      end
      ADDIWB: begin
        reg_write  = 1'b1;
        retire_inc = 1'b1;
        state_next = FETCH;
      end
      JUMP: begin
        pc_src     = 2'b10;
        pc_write   = 1'b1;
        retire_inc = 1'b1;
        state_next = FETCH;
      end
`ifdef MULTI_CTRL_ILLEGAL_TRAP_EN
      HALT:    state_next = HALT;
`else
      HALT:    state_next = FETCH;
`endif
      default: state_next = FETCH;
    endcase

    pc_en = pc_write | (branch & zero);

    // Strobes stay quiet for the whole reset cycle, whatever state is held.
    if (reset) begin
      mem_req   = 1'b0;
      mem_write = 1'b0;
      ir_write  = 1'b0;
      pc_en     = 1'b0;
      reg_write = 1'b0;
    end
  end

  assign retired   = retired_reg;
  assign state_dbg = state_reg;

endmodule

// File: tb/tb_multi_ctrl.sv
// Directed testbench for multi_ctrl; strobes checked as {mem_req,mem_write,ir_write,pc_en,reg_write}.
module tb_multi_ctrl;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ILL   = 6'b111111;

  logic        clk = 1'b0;
  logic        reset, zero, mem_ready;
  logic [5:0]  op;
  logic        mem_req, mem_write, iord, ir_write, pc_en;
  logic [1:0]  pc_src, alu_src_b, alu_op;
  logic        alu_src_a, reg_dst, mem_to_reg, reg_write;
  logic [31:0] retired;
  logic [3:0]  state_dbg;
  logic [4:0]  strb;

  int vectors = 0;
  int miscompares = 0;

  multi_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_write(mem_write), .iord(iord), .ir_write(ir_write),
    .pc_en(pc_en), .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .retired(retired), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;
  assign strb = {mem_req, mem_write, ir_write, pc_en, reg_write};

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    mem_ready = 1'b1;
    op = OP_RTYPE;
    reset = 1'b1;
    tick();
    tick();
    #1;
    vectors++;
    if (strb !== 5'b00000) begin
      miscompares++;
      $display("FAIL reset_strobes: got %b want 00000", strb);
    end
    reset = 1'b0;
    #1;
    vectors++;
    if (state_dbg !== 4'd0 || strb !== 5'b10110 || retired !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_cyc0: state %0d strb %b ret %0d want 0 10110 0", state_dbg, strb, retired);
    end
    $display("reset: cyc0 state %0d strb %b retired %0d", state_dbg, strb, retired);
    tick();
    vectors++;
    if (state_dbg !== 4'd1) begin
      miscompares++;
      $display("FAIL reset_cyc1: state %0d want 1", state_dbg);
    end
  endtask

  task automatic test_lw();
    int         st[6]  = '{0, 1, 2, 3, 4, 0};
    logic [4:0] sb[6]  = '{5'b10110, 5'b00000, 5'b00000, 5'b10000, 5'b00001, 5'b10110};
    int         rt[6]  = '{0, 0, 0, 0, 0, 1};
    do_reset();
    op = OP_LW;
    mem_ready = 1'b1;
    zero = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      vectors++;
      if (state_dbg !== 4'(st[i]) || strb !== sb[i] || retired !== 32'(rt[i])) begin
        miscompares++;
        $display("FAIL lw cyc%0d: state %0d strb %b ret %0d want %0d %b %0d",
                 i, state_dbg, strb, retired, st[i], sb[i], rt[i]);
      end
      if (i == 3 || i == 4) begin
        vectors++;
        if ((i == 3 && iord !== 1'b1) || (i == 4 && mem_to_reg !== 1'b1)) begin
          miscompares++;
          $display("FAIL lw_sel cyc%0d: iord %b mem_to_reg %b want 1", i, iord, mem_to_reg);
        end
      end
      $display("lw cyc%0d: state %0d strb %b retired %0d", i, state_dbg, strb, retired);
      tick();
    end
  endtask

  task automatic test_sw_wait();
    int         st[8] = '{0, 1, 2, 5, 5, 5, 5, 0};
    logic       rd[8] = '{1, 1, 1, 0, 0, 0, 1, 1};
    logic [4:0] sb[8] = '{5'b10110, 5'b00000, 5'b00000, 5'b11000, 5'b11000, 5'b11000,
                          5'b11000, 5'b10110};
    int         rt[8] = '{0, 0, 0, 0, 0, 0, 0, 1};
    do_reset();
    op = OP_SW;
    for (int i = 0; i < 8; i++) begin
      mem_ready = rd[i];
      #1;
      vectors++;
      if (state_dbg !== 4'(st[i]) || strb !== sb[i] || retired !== 32'(rt[i]) ||
          (st[i] == 5 && iord !== 1'b1)) begin
        miscompares++;
        $display("FAIL sw cyc%0d: state %0d strb %b ret %0d iord %b want %0d %b %0d",
                 i, state_dbg, strb, retired, iord, st[i], sb[i], rt[i]);
      end
      $display("sw cyc%0d: ready %b state %0d strb %b retired %0d", i, rd[i], state_dbg, strb, retired);
      tick();
    end
  endtask

  task automatic test_rtype();
    int         st[5] = '{0, 1, 6, 7, 0};
    logic [4:0] sb[5] = '{5'b10110, 5'b00000, 5'b00000, 5'b00001, 5'b10110};
    int         rt[5] = '{0, 0, 0, 0, 1};
    do_reset();
    op = OP_RTYPE;
    mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      vectors++;
      if (state_dbg !== 4'(st[i]) || strb !== sb[i] || retired !== 32'(rt[i]) ||
          (i == 2 && (alu_op !== 2'b10 || alu_src_a !== 1'b1)) || (i == 3 && reg_dst !== 1'b1)) begin
        miscompares++;
        $display("FAIL rtype cyc%0d: state %0d strb %b ret %0d alu_op %b reg_dst %b want %0d %b %0d",
                 i, state_dbg, strb, retired, alu_op, reg_dst, st[i], sb[i], rt[i]);
      end
      $display("rtype cyc%0d: state %0d strb %b retired %0d", i, state_dbg, strb, retired);
      tick();
    end
  endtask

  task automatic test_beq();
    int         st[7] = '{0, 1, 8, 0, 1, 8, 0};
    logic       zf[7] = '{0, 1, 1, 0, 1, 0, 0};
    logic [4:0] sb[7] = '{5'b10110, 5'b00000, 5'b00010, 5'b10110, 5'b00000, 5'b00000, 5'b10110};
    int         rt[7] = '{0, 0, 0, 1, 1, 1, 2};
    do_reset();
    op = OP_BEQ;
    mem_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      zero = zf[i];
      #1;
      vectors++;
      if (state_dbg !== 4'(st[i]) || strb !== sb[i] || retired !== 32'(rt[i]) ||
          (st[i] == 8 && pc_src !== 2'b01)) begin
        miscompares++;
        $display("FAIL beq cyc%0d: state %0d strb %b ret %0d pc_src %b want %0d %b %0d",
                 i, state_dbg, strb, retired, pc_src, st[i], sb[i], rt[i]);
      end
      $display("beq cyc%0d: zero %b state %0d strb %b retired %0d", i, zf[i], state_dbg, strb, retired);
      tick();
    end
    zero = 1'b0;
  endtask

  task automatic test_jump_illegal();
    int         st[15];
    logic [4:0] sb[15];
    int         rt[15];
    st[0] = 0; sb[0] = 5'b10110; rt[0] = 0;
    st[1] = 1; sb[1] = 5'b00000; rt[1] = 0;
    st[2] = 11; sb[2] = 5'b00010; rt[2] = 0;
    st[3] = 0; sb[3] = 5'b10110; rt[3] = 1;
    st[4] = 1; sb[4] = 5'b00000; rt[4] = 1;
    for (int i = 5; i < 15; i++) begin
      rt[i] = 1;
`ifdef MULTI_CTRL_ILLEGAL_TRAP_EN
      st[i] = 12;
      sb[i] = 5'b00000;
`else
      st[i] = (i % 2 == 1) ? 0 : 1;
      sb[i] = (i % 2 == 1) ? 5'b10110 : 5'b00000;
`endif
    end
    do_reset();
    mem_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      op = (i < 3) ? OP_J : OP_ILL;
      #1;
      vectors++;
      if (state_dbg !== 4'(st[i]) || strb !== sb[i] || retired !== 32'(rt[i]) ||
          (i == 2 && pc_src !== 2'b10)) begin
        miscompares++;
        $display("FAIL j_ill cyc%0d: state %0d strb %b ret %0d pc_src %b want %0d %b %0d",
                 i, state_dbg, strb, retired, pc_src, st[i], sb[i], rt[i]);
      end
      $display("j_ill cyc%0d: op %b state %0d strb %b retired %0d", i, op, state_dbg, strb, retired);
      tick();
    end
  endtask

  task automatic test_reset_midinstr();
    int st[9] = '{0, 1, 9, 10, 0, 1, 2, 3, 3};
    int rt[9] = '{0, 0, 0, 0, 1, 1, 1, 1, 1};
    do_reset();
    for (int i = 0; i < 9; i++) begin
      op = (i < 4) ? OP_ADDI : OP_LW;
      mem_ready = (i < 7 && st[i] == 0) ? 1'b1 : 1'b0;
      if (i == 8) begin
        mem_ready = 1'b1;
        reset = 1'b1;
      end
      #1;
      vectors++;
      if (state_dbg !== 4'(st[i]) || retired !== 32'(rt[i]) ||
          (i == 3 && (reg_write !== 1'b1 || reg_dst !== 1'b0)) ||
          (i == 7 && (mem_req !== 1'b1 || iord !== 1'b1 || reg_write !== 1'b0)) ||
          (i == 8 && strb !== 5'b00000)) begin
        miscompares++;
        $display("FAIL rst_mid cyc%0d: state %0d ret %0d strb %b want state %0d ret %0d",
                 i, state_dbg, retired, strb, st[i], rt[i]);
      end
      $display("rst_mid cyc%0d: state %0d strb %b retired %0d", i, state_dbg, strb, retired);
      tick();
    end
    reset = 1'b0;
    mem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      vectors++;
      if (state_dbg !== 4'd0 || retired !== 32'd0 || strb !== 5'b10000) begin
        miscompares++;
        $display("FAIL rst_mid_after cyc%0d: state %0d ret %0d strb %b want 0 0 10000",
                 i, state_dbg, retired, strb);
      end
      $display("rst_mid after cyc%0d: state %0d strb %b retired %0d", i, state_dbg, strb, retired);
      tick();
    end
  endtask

  initial begin
    reset = 1'b1;
    op = OP_RTYPE;
    zero = 1'b0;
    mem_ready = 1'b0;
    test_reset();
    test_lw();
    test_sw_wait();
    test_rtype();
    test_beq();
    test_jump_illegal();
    test_reset_midinstr();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
